// File: rtl/seg_write_arbiter.sv
// Arbitrates three segment-register write requesters onto one registered write port,
// with a lockable far-transfer owner and an SS-write shadow that briefly holds off interrupts.
module seg_write_arbiter #(
   parameter int unsigned SHADOW_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic [1:0]  sel0,
   input  logic [15:0] data0,
   input  logic        req1,
   input  logic [1:0]  sel1,
   input  logic [15:0] data1,
   input  logic        lock1,
   input  logic        req2,
   input  logic [1:0]  sel2,
   input  logic [15:0] data2,
   output logic        gnt0,
   output logic        gnt1,
   output logic        gnt2,
   output logic        write_en,
   output logic [1:0]  reg_select,
   output logic [15:0] data,
   output logic        locked,
   output logic        ss_shadow
);

   localparam logic [1:0] SEG_SS      = 2'b10;
   localparam logic [3:0] SHADOW_LOAD = 4'(SHADOW_CYCLES);

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_gnt0, r_gnt1, r_gnt2;
   logic        r_write_en;
   logic [1:0]  r_reg_select;
   logic [15:0] r_data;
   logic [3:0]  r_shadow_cnt;
   logic        r_ss_shadow;

   logic        w_elig0, w_elig1, w_elig2;
   logic        w_gnt0, w_gnt1, w_gnt2;
   logic        w_write_en;
   logic [1:0]  w_sel;
   logic [15:0] w_data;
   logic [3:0]  w_shadow_cnt_nxt;

   // A requester that holds req through its own grant cycle is not served twice in a row.
   always_comb begin
      w_elig2 = req2 & ~r_gnt2 & ~r_ss_shadow & (r_state == ST_UNLOCKED);
      w_elig1 = req1 & ~r_gnt1;
      w_elig0 = req0 & ~r_gnt0 & (r_state == ST_UNLOCKED);
   end

   always_comb begin
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      w_gnt2      = 1'b0;
      w_sel       = r_reg_select;
      w_data      = r_data;
      w_state_nxt = r_state;

      if (w_elig2) begin
         w_gnt2 = 1'b1;
         w_sel  = sel2;
         w_data = data2;
      end else if (w_elig1) begin
         w_gnt1 = 1'b1;
         w_sel  = sel1;
         w_data = data1;
      end else if (w_elig0) begin
         w_gnt0 = 1'b1;
         w_sel  = sel0;
         w_data = data0;
      end
      w_write_en = w_gnt0 | w_gnt1 | w_gnt2;

      case (r_state)
         ST_UNLOCKED: if (w_gnt1 && lock1) w_state_nxt = ST_LOCKED;
         ST_LOCKED:   if (!lock1 && (w_gnt1 || !req1)) w_state_nxt = ST_UNLOCKED;
         default:     w_state_nxt = ST_UNLOCKED;
      endcase

      if (w_write_en && (w_sel == SEG_SS)) begin
         w_shadow_cnt_nxt = SHADOW_LOAD;
      end else if (r_shadow_cnt != 4'd0) begin
         w_shadow_cnt_nxt = r_shadow_cnt - 4'd1;
      end else begin
         w_shadow_cnt_nxt = 4'd0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_UNLOCKED;
         r_gnt0       <= 1'b0;
         r_gnt1       <= 1'b0;
         r_gnt2       <= 1'b0;
         r_write_en   <= 1'b0;
         r_reg_select <= 2'b00;
         r_data       <= 16'h0000;
         r_shadow_cnt <= 4'd0;
         r_ss_shadow  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_gnt0       <= w_gnt0;
         r_gnt1       <= w_gnt1;
         r_gnt2       <= w_gnt2;
         r_write_en   <= w_write_en;
         r_reg_select <= w_sel;
         r_data       <= w_data;
         r_shadow_cnt <= w_shadow_cnt_nxt;
         r_ss_shadow  <= (w_shadow_cnt_nxt != 4'd0);
      end
   end

   assign gnt0       = r_gnt0;
   assign gnt1       = r_gnt1;
   assign gnt2       = r_gnt2;
   assign write_en   = r_write_en;
   assign reg_select = r_reg_select;
   assign data       = r_data;
   assign locked     = (r_state == ST_LOCKED);
   assign ss_shadow  = r_ss_shadow;

endmodule

// File: tb/tb_seg_write_arbiter.sv
// Bench for seg_write_arbiter: directed scenarios with fixed expectations, then random
// traffic checked cycle by cycle against a rule-level reference model.
module tb_seg_write_arbiter;

   localparam int SHADOW = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0, req2 = 1'b0, lock1 = 1'b0;
   logic [1:0]  sel0 = 2'b00, sel1 = 2'b00, sel2 = 2'b00;
   logic [15:0] data0 = 16'h0, data1 = 16'h0, data2 = 16'h0;
   logic        gnt0, gnt1, gnt2, write_en, locked, ss_shadow;
   logic [1:0]  reg_select;
   logic [15:0] data;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: what the write port should show after the next edge.
   bit [2:0]    m_gnt;
   bit          m_we;
   bit [1:0]    m_sel;
   bit [15:0]   m_data;
   bit          m_locked;
   int          m_shadow;

   always #5 clk = ~clk;

   seg_write_arbiter #(.SHADOW_CYCLES(SHADOW)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .sel0(sel0), .data0(data0),
      .req1(req1), .sel1(sel1), .data1(data1), .lock1(lock1),
      .req2(req2), .sel2(sel2), .data2(data2),
      .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
      .write_en(write_en), .reg_select(reg_select), .data(data),
      .locked(locked), .ss_shadow(ss_shadow)
   );

   task automatic model_reset();
      m_gnt = 3'b000; m_we = 1'b0; m_sel = 2'b00; m_data = 16'h0;
      m_locked = 1'b0; m_shadow = 0;
   endtask

   // Called at a falling edge with inputs stable: predicts the next edge, then advances to
   // the following falling edge where outputs are sampled.
   task automatic tick();
      bit e0, e1, e2;
      int win;
      e2 = req2 && !m_gnt[2] && (m_shadow == 0) && !m_locked;
      e1 = req1 && !m_gnt[1];
      e0 = req0 && !m_gnt[0] && !m_locked;
      win = e2 ? 2 : (e1 ? 1 : (e0 ? 0 : -1));
      if (!m_locked) begin
         if (win == 1 && lock1) m_locked = 1'b1;
      end else if (!lock1 && (win == 1 || !req1)) begin
         m_locked = 1'b0;
      end
      if (m_shadow > 0) m_shadow = m_shadow - 1;
      m_gnt = 3'b000;
      m_we  = (win >= 0);
      if (win >= 0) begin
         m_gnt[win] = 1'b1;
         m_sel  = (win == 2) ? sel2  : ((win == 1) ? sel1  : sel0);
         m_data = (win == 2) ? data2 : ((win == 1) ? data1 : data0);
         if (m_sel == 2'b10) m_shadow = SHADOW;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      @(negedge clk);
      n_checks++; if ({gnt2, gnt1, gnt0, write_en} !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt_we: got %b expected 0000", {gnt2, gnt1, gnt0, write_en}); end
      n_checks++; if (reg_select !== 2'b00) begin n_fail++; $display("FAIL reset_sel: got %b expected 00", reg_select); end
      n_checks++; if (data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", data); end
      n_checks++; if ({locked, ss_shadow} !== 2'b00) begin n_fail++; $display("FAIL reset_lock_shadow: got %b expected 00", {locked, ss_shadow}); end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_single();
      req0 = 1'b1; sel0 = 2'b01; data0 = 16'h1234;
      tick();
      n_checks++; if ({gnt2, gnt1, gnt0, write_en} !== 4'b0011) begin n_fail++; $display("FAIL single_grant: got %b expected 0011", {gnt2, gnt1, gnt0, write_en}); end
      n_checks++; if ({reg_select, data} !== {2'b01, 16'h1234}) begin n_fail++; $display("FAIL single_write: got %b/%h expected 01/1234", reg_select, data); end
      req0 = 1'b0;
      tick();
      n_checks++; if ({gnt0, write_en} !== 2'b00) begin n_fail++; $display("FAIL single_idle: got %b expected 00", {gnt0, write_en}); end
      n_checks++; if ({reg_select, data} !== {2'b01, 16'h1234}) begin n_fail++; $display("FAIL single_hold: got %b/%h expected 01/1234", reg_select, data); end
   endtask

   task automatic test_priority();
      req0 = 1'b1; sel0 = 2'b00; data0 = 16'hA000;
      req1 = 1'b1; sel1 = 2'b01; data1 = 16'hA001; lock1 = 1'b0;
      req2 = 1'b1; sel2 = 2'b11; data2 = 16'hA002;
      tick();
      n_checks++; if ({gnt2, gnt1, gnt0, data} !== {3'b100, 16'hA002}) begin n_fail++; $display("FAIL prio_first: got %b/%h expected 100/a002", {gnt2, gnt1, gnt0}, data); end
      req2 = 1'b0;
      tick();
      n_checks++; if ({gnt2, gnt1, gnt0, data} !== {3'b010, 16'hA001}) begin n_fail++; $display("FAIL prio_second: got %b/%h expected 010/a001", {gnt2, gnt1, gnt0}, data); end
      req1 = 1'b0;
      tick();
      n_checks++; if ({gnt2, gnt1, gnt0, data} !== {3'b001, 16'hA000}) begin n_fail++; $display("FAIL prio_third: got %b/%h expected 001/a000", {gnt2, gnt1, gnt0}, data); end
      req0 = 1'b0;
      tick();
      n_checks++; if ({gnt2, gnt1, gnt0, write_en} !== 4'b0000) begin n_fail++; $display("FAIL prio_idle: got %b expected 0000", {gnt2, gnt1, gnt0, write_en}); end
   endtask

   task automatic test_same_requester();
      req0 = 1'b1; sel0 = 2'b11; data0 = 16'h5555;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if (gnt0 !== ((i % 2) == 0)) begin n_fail++; $display("FAIL same_req_cycle%0d: got %b expected %b", i, gnt0, (i % 2) == 0); end
      end
      req0 = 1'b0;
      tick();
   endtask

   task automatic test_ss_shadow();
      req0 = 1'b1; sel0 = 2'b10; data0 = 16'h0800;
      tick();
      n_checks++; if ({gnt0, reg_select, data, ss_shadow} !== {1'b1, 2'b10, 16'h0800, 1'b1}) begin n_fail++; $display("FAIL ss_write: got %b/%b/%h/%b expected 1/10/0800/1", gnt0, reg_select, data, ss_shadow); end
      req0 = 1'b0; req2 = 1'b1; sel2 = 2'b00; data2 = 16'hBEEF;
      tick();
      n_checks++; if ({gnt2, ss_shadow} !== 2'b01) begin n_fail++; $display("FAIL ss_hold1: got %b expected 01", {gnt2, ss_shadow}); end
      tick();
      n_checks++; if ({gnt2, ss_shadow} !== 2'b00) begin n_fail++; $display("FAIL ss_hold2: got %b expected 00", {gnt2, ss_shadow}); end
      tick();
      n_checks++; if ({gnt2, data} !== {1'b1, 16'hBEEF}) begin n_fail++; $display("FAIL ss_release: got %b/%h expected 1/beef", gnt2, data); end
      req2 = 1'b0;
      tick();
   endtask

   task automatic test_lock();
      req1 = 1'b1; lock1 = 1'b1; sel1 = 2'b11; data1 = 16'h1111;
      tick();
      n_checks++; if ({gnt1, locked} !== 2'b11) begin n_fail++; $display("FAIL lock_enter: got %b expected 11", {gnt1, locked}); end
      req1 = 1'b0;
      req2 = 1'b1; sel2 = 2'b01; data2 = 16'h2222;
      req0 = 1'b1; sel0 = 2'b00; data0 = 16'h3333;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if ({gnt2, gnt1, gnt0, write_en, locked} !== 5'b00001) begin n_fail++; $display("FAIL lock_wait%0d: got %b expected 00001", i, {gnt2, gnt1, gnt0, write_en, locked}); end
      end
      req1 = 1'b1; lock1 = 1'b0; data1 = 16'h4444;
      tick();
      n_checks++; if ({gnt1, locked, data} !== {2'b10, 16'h4444}) begin n_fail++; $display("FAIL lock_exit: got %b/%h expected 10/4444", {gnt1, locked}, data); end
      req1 = 1'b0;
      tick();
      n_checks++; if ({gnt2, gnt0, data} !== {2'b10, 16'h2222}) begin n_fail++; $display("FAIL lock_after2: got %b/%h expected 10/2222", {gnt2, gnt0}, data); end
      req2 = 1'b0;
      tick();
      n_checks++; if ({gnt2, gnt0, data} !== {2'b01, 16'h3333}) begin n_fail++; $display("FAIL lock_after0: got %b/%h expected 01/3333", {gnt2, gnt0}, data); end
      req0 = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      req1 = 1'b1; lock1 = 1'b1; sel1 = 2'b01; data1 = 16'hABCD;
      tick();
      n_checks++; if ({gnt1, write_en, locked} !== 3'b111) begin n_fail++; $display("FAIL rstmid_pre: got %b expected 111", {gnt1, write_en, locked}); end
      #2 rst = 1'b0;
      #1;
      n_checks++; if ({gnt1, write_en, locked, ss_shadow} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_drop: got %b expected 0000", {gnt1, write_en, locked, ss_shadow}); end
      n_checks++; if ({reg_select, data} !== 18'h0) begin n_fail++; $display("FAIL rstmid_port: got %b/%h expected 00/0000", reg_select, data); end
      @(posedge clk);
      @(negedge clk);
      n_checks++; if ({gnt1, write_en} !== 2'b00) begin n_fail++; $display("FAIL rstmid_held: got %b expected 00", {gnt1, write_en}); end
      rst = 1'b1;
      model_reset();
      tick();
      n_checks++; if ({gnt1, write_en, data} !== {2'b11, 16'hABCD}) begin n_fail++; $display("FAIL rstmid_restart: got %b/%h expected 11/abcd", {gnt1, write_en}, data); end
      req1 = 1'b0; lock1 = 1'b0;
      tick();
      n_checks++; if ({gnt1, locked} !== 2'b00) begin n_fail++; $display("FAIL rstmid_unlock: got %b expected 00", {gnt1, locked}); end
   endtask

   task automatic test_random();
      logic [23:0] act, exp;
      for (int c = 0; c < 400; c++) begin
         req0  = ($urandom_range(0, 1) == 1);
         req1  = ($urandom_range(0, 2) == 0);
         req2  = ($urandom_range(0, 1) == 1);
         lock1 = ($urandom_range(0, 3) == 0);
         sel0  = 2'($urandom_range(0, 3));
         sel1  = 2'($urandom_range(0, 3));
         sel2  = 2'($urandom_range(0, 3));
         data0 = 16'($urandom);
         data1 = 16'($urandom);
         data2 = 16'($urandom);
         tick();
         act = {gnt2, gnt1, gnt0, write_en, reg_select, data, locked, ss_shadow};
         exp = {m_gnt, m_we, m_sel, m_data, m_locked, (m_shadow != 0)};
         n_checks++; if (act !== exp) begin n_fail++; $display("FAIL random_cycle%0d: got %h expected %h", c, act, exp); end
      end
      {req0, req1, req2, lock1} = 4'b0000;
      tick();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_priority();
      test_same_requester();
      test_ss_shadow();
      test_lock();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
